// File: rtl/option_streamer.sv
// Circular option buffer that replays line indices and their candidate options to the solver,
// re-enqueuing the options the solver keeps and tracking per-line option counts.
module option_streamer #(
    parameter int unsigned SIZE     = 11,
    parameter int unsigned OPT_W    = 16,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned OPT_HOLD = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic                    load_is_index,
    input  logic [OPT_W-1:0]        load_data,
    output logic                    load_ready,
    input  logic                    load_done,
    output logic                    started,
    output logic [OPT_W-1:0]        option,
    output logic                    option_is_index,
    output logic [2*SIZE-1:0][6:0]  old_options_amnt,
    input  logic                    new_line,
    input  logic                    put_back_to_FIFO,
    input  logic [OPT_W-1:0]        new_option,
    input  logic                    solved,
    output logic                    done,
    output logic                    overflow
);

    localparam int unsigned Lines = 2 * SIZE;
    localparam int unsigned LineW = $clog2(Lines);
    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned HoldW = (OPT_HOLD > 1) ? $clog2(OPT_HOLD) : 1;

    typedef enum logic [3:0] {
        StIdle, StLoad, StStart, StSendIdx, StSendOpt, StLineEnd, StDone, StStall, StError
    } state_e;

    state_e                   state_q, state_d;
    logic [OPT_W:0]           mem_q [DEPTH];
    logic [AddrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]           count_q, count_d;
    logic [Lines-1:0][6:0]    amnt_q, amnt_d;
    logic [OPT_W-1:0]         last_idx_q, last_idx_d;
    logic [LineW-1:0]         cur_line_q, cur_line_d;
    logic [6:0]               kept_q, kept_d, left_q, left_d;
    logic [HoldW-1:0]         hold_q, hold_d;
    logic                     pushed_q, pushed_d, seen_q, seen_d, shrunk_q, shrunk_d;
    logic                     overflow_q;

    logic                     push, pop, do_push, do_pop, full, empty;
    logic [OPT_W:0]           push_data, head;
    logic                     end_line, line_shrank, abort;
    logic [LineW-1:0]         line_done_idx;

    assign full    = (count_q == (AddrW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || pop);
    assign count_d = count_q + (AddrW + 1)'(do_push) - (AddrW + 1)'(do_pop);

    assign old_options_amnt = amnt_q;
    assign overflow         = overflow_q;

    always_comb begin
        state_d         = state_q;
        push            = 1'b0;
        push_data       = '0;
        pop             = 1'b0;
        load_ready      = 1'b0;
        started         = 1'b0;
        option          = '0;
        option_is_index = 1'b0;
        done            = 1'b0;
        amnt_d          = amnt_q;
        last_idx_d      = last_idx_q;
        cur_line_d      = cur_line_q;
        kept_d          = kept_q;
        left_d          = left_q;
        hold_d          = hold_q;
        pushed_d        = pushed_q;
        seen_d          = seen_q;
        shrunk_d        = shrunk_q;
        end_line        = 1'b0;
        line_shrank     = 1'b0;
        line_done_idx   = cur_line_q;
        abort           = 1'b0;

        unique case (state_q)
            StIdle: if (load_valid) state_d = StLoad;
            StLoad: begin
                load_ready = !full;
                if (load_valid) begin
                    push      = 1'b1;
                    push_data = {load_is_index, load_data};
                    if (!full) begin
                        if (load_is_index) begin
                            last_idx_d = load_data;
                        end else if (last_idx_q < OPT_W'(Lines)) begin
                            if (amnt_q[last_idx_q[LineW-1:0]] != 7'd127) begin
                                amnt_d[last_idx_q[LineW-1:0]] = amnt_q[last_idx_q[LineW-1:0]] + 7'd1;
                            end
                        end
                    end
                end
                if (load_done) state_d = StStart;
            end
            StStart: begin
                started  = 1'b1;
                shrunk_d = 1'b0;
                state_d  = StSendIdx;
            end
            StSendIdx: begin
                if (empty || !head[OPT_W] || head[OPT_W-1:0] >= OPT_W'(Lines)) begin
                    state_d = StError;
                end else begin
                    option          = head[OPT_W-1:0];
                    option_is_index = 1'b1;
                    pop             = 1'b1;
                    push            = 1'b1;
                    push_data       = head;
                    cur_line_d      = head[LineW-1:0];
                    kept_d          = '0;
                    left_d          = amnt_q[head[LineW-1:0]];
                    hold_d          = '0;
                    pushed_d        = 1'b0;
                    seen_d          = 1'b0;
                    if (amnt_q[head[LineW-1:0]] == '0) begin
                        end_line      = 1'b1;
                        line_done_idx = head[LineW-1:0];
                    end else begin
                        state_d = StSendOpt;
                    end
                end
            end
            StSendOpt: begin
                if (empty || head[OPT_W]) begin
                    state_d = StError;
                end else begin
                    option = head[OPT_W-1:0];
                    abort  = new_line || seen_q;
                    seen_d = abort;
                    if (!abort && put_back_to_FIFO && !pushed_q) begin
                        push      = 1'b1;
                        push_data = {1'b0, new_option};
                        pushed_d  = 1'b1;
                        kept_d    = kept_q + 7'd1;
                    end
                    // Early new_line drains the rest of the line one word per cycle.
                    if (abort || hold_q == HoldW'(OPT_HOLD - 1)) begin
                        pop      = 1'b1;
                        hold_d   = '0;
                        pushed_d = 1'b0;
                        left_d   = left_q - 7'd1;
                        if (left_q == 7'd1) state_d = StLineEnd;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end
            end
            StLineEnd: begin
                if (seen_q || new_line) begin
                    end_line           = 1'b1;
                    line_shrank        = kept_q < amnt_q[cur_line_q];
                    amnt_d[cur_line_q] = kept_q;
                end
            end
            StDone, StStall, StError: done = 1'b1;
            default: state_d = StError;
        endcase

        if (end_line) begin
            if (line_done_idx == LineW'(Lines - 1)) begin
                if (!(shrunk_q || line_shrank)) begin
                    state_d = StStall;
                end else begin
                    state_d  = StSendIdx;
                    shrunk_d = 1'b0;
                end
            end else begin
                state_d  = StSendIdx;
                shrunk_d = shrunk_q || line_shrank;
            end
        end

        if (solved && (state_q inside {StStart, StSendIdx, StSendOpt, StLineEnd})) begin
            state_d = StDone;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            amnt_q     <= '0;
            last_idx_q <= '1;
            cur_line_q <= '0;
            kept_q     <= '0;
            left_q     <= '0;
            hold_q     <= '0;
            pushed_q   <= 1'b0;
            seen_q     <= 1'b0;
            shrunk_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            amnt_q     <= amnt_d;
            last_idx_q <= last_idx_d;
            cur_line_q <= cur_line_d;
            kept_q     <= kept_d;
            left_q     <= left_d;
            hold_q     <= hold_d;
            pushed_q   <= pushed_d;
            seen_q     <= seen_d;
            shrunk_q   <= shrunk_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_option_streamer.sv
// Randomized bench for option_streamer: a per-line option-list model predicts the replayed stream,
// the per-line counts, stall/solved termination and overflow behaviour.
module tb_option_streamer;

    localparam int Lines = 22;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   load_valid, load_is_index, load_done, new_line, put_back, solved;
    logic [15:0]            load_data, new_option;
    logic                   load_ready, started, option_is_index, done, overflow;
    logic [15:0]            option;
    logic [Lines-1:0][6:0]  amnt;

    logic                   s_valid, s_is_index, s_ld_done;
    logic [15:0]            s_data;
    logic                   s_ready, s_started, s_opt_idx, s_done, s_ovf;
    logic [15:0]            s_option;
    logic [Lines-1:0][6:0]  s_amnt;
    logic                   zero_b = 1'b0;
    logic [15:0]            zero_w = '0;

    int n_checks = 0;
    int n_errs   = 0;
    int unsigned opts [Lines][$];

    option_streamer dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_is_index(load_is_index),
        .load_data(load_data), .load_ready(load_ready), .load_done(load_done), .started(started),
        .option(option), .option_is_index(option_is_index), .old_options_amnt(amnt),
        .new_line(new_line), .put_back_to_FIFO(put_back), .new_option(new_option),
        .solved(solved), .done(done), .overflow(overflow)
    );

    option_streamer #(.DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .load_valid(s_valid), .load_is_index(s_is_index),
        .load_data(s_data), .load_ready(s_ready), .load_done(s_ld_done), .started(s_started),
        .option(s_option), .option_is_index(s_opt_idx), .old_options_amnt(s_amnt),
        .new_line(zero_b), .put_back_to_FIFO(zero_b), .new_option(zero_w),
        .solved(zero_b), .done(s_done), .overflow(s_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int total_words();
        int t = Lines;
        for (int l = 0; l < Lines; l++) t += opts[l].size();
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {load_valid, load_is_index, load_done, new_line, put_back, solved} = '0;
        {s_valid, s_is_index, s_ld_done} = '0;
        load_data = '0; new_option = '0; s_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic make_xboard();
        for (int l = 0; l < Lines; l++) begin
            int r = l % 11;
            int unsigned v = (r == 0) ? 32'h7ff : (32'h7ff & ~((32'd1 << r) | (32'd1 << (10 - r))));
            opts[l].delete();
            opts[l].push_back(v);
        end
    endtask

    task automatic push_word(input logic is_idx, input logic [15:0] data);
        int t = 0;
        load_valid = 1'b1; load_is_index = is_idx; load_data = data;
        while (!load_ready && t < 10) begin @(negedge clk); t++; end
        if (!load_ready) check("load_ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic load_model();
        for (int l = 0; l < Lines; l++) begin
            push_word(1'b1, 16'(l));
            foreach (opts[l][k]) push_word(1'b0, 16'(opts[l][k]));
        end
        load_valid = 1'b0; load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
        check("started", started, 1);
        for (int l = 0; l < Lines; l++) check($sformatf("load_amnt%0d", l), amnt[l], opts[l].size());
        @(negedge clk);
        check("first_idx_latency", option_is_index, 1);
    endtask

    // mode 0: keep all; 1: random keep; 2: line 3 keeps only its 2nd option
    task automatic run_pass(input int mode, input int stop_line, output bit shrunk);
        shrunk = 1'b0;
        for (int l = 0; l < stop_line; l++) begin
            int unsigned kept [$];
            int n = opts[l].size();
            int t = 0;
            while (!option_is_index && t < 8) begin @(negedge clk); t++; end
            check($sformatf("idx_flag%0d", l), option_is_index, 1);
            check($sformatf("idx%0d", l), option, l);
            check($sformatf("amnt%0d", l), amnt[l], n);
            @(negedge clk);
            for (int k = 0; k < n; k++) begin
                bit keep;
                int pat;
                case (mode)
                    0: keep = 1'b1;
                    1: keep = ($urandom_range(0, 3) != 0);
                    default: keep = (l != 3) || (k == 1);
                endcase
                pat = keep ? ((mode == 1) ? int'($urandom_range(1, 3)) : 1) : 0;
                check($sformatf("opt%0d_%0d_c0", l, k), {15'd0, option_is_index, option},
                      opts[l][k]);
                new_option = 16'(opts[l][k]);
                put_back = pat[0];
                @(negedge clk);
                check($sformatf("opt%0d_%0d_c1", l, k), {15'd0, option_is_index, option},
                      opts[l][k]);
                put_back = pat[1];
                @(negedge clk);
                put_back = 1'b0;
                if (keep) kept.push_back(opts[l][k]);
            end
            if (n > 0) begin
                check($sformatf("line_end%0d", l), {done, option_is_index}, 0);
                new_line = 1'b1;
                @(negedge clk);
                new_line = 1'b0;
            end
            if (kept.size() < n) shrunk = 1'b1;
            opts[l] = kept;
        end
    endtask

    task automatic check_stall(input string tag);
        int exp_cnt = total_words();
        check({tag, "_done"}, done, 1);
        check({tag, "_opt"}, {15'd0, option_is_index, option}, 0);
        repeat (3) @(negedge clk);
        check({tag, "_done_held"}, done, 1);
        check({tag, "_count"}, dut.count_q, exp_cnt);
    endtask

    initial begin
        bit sh;
        do_reset();
        check("rst_outputs", {load_ready, started, option_is_index, done, overflow}, 0);
        check("rst_option", option, 0);
        check("rst_count", dut.count_q, 0);

        // Reset in the middle of loading
        make_xboard();
        push_word(1'b1, 16'd0); push_word(1'b0, 16'(opts[0][0]));
        push_word(1'b1, 16'd1); push_word(1'b0, 16'(opts[1][0]));
        rst_n = 1'b0; load_valid = 1'b0;
        @(negedge clk);
        check("midload_outputs", {load_ready, started, option_is_index, done, overflow}, 0);
        check("midload_option", option, 0);
        check("midload_count", dut.count_q, 0);
        check("midload_amnt", 32'(|amnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // X-board, everything kept: one pass then stall
        make_xboard();
        load_model();
        run_pass(0, Lines, sh);
        check("xboard_no_shrink", 32'(sh), 0);
        check_stall("xboard_stall");

        // Line 3 with three options, only the second survives
        do_reset();
        make_xboard();
        opts[3].delete();
        for (int k = 0; k < 3; k++) opts[3].push_back(32'h100 + k);
        load_model();
        run_pass(2, Lines, sh);
        check("line3_shrank", 32'(sh), 1);
        run_pass(0, Lines, sh);
        check("line3_second_pass", 32'(sh), 0);
        check_stall("line3_stall");

        // solved during an option hold with put_back
        do_reset();
        make_xboard();
        load_model();
        run_pass(0, 5, sh);
        begin
            int t = 0;
            while (!option_is_index && t < 8) begin @(negedge clk); t++; end
        end
        check("solve_idx5", option, 5);
        @(negedge clk);
        check("solve_opt5", option, opts[5][0]);
        put_back = 1'b1; new_option = 16'(opts[5][0]); solved = 1'b1;
        @(negedge clk);
        put_back = 1'b0; solved = 1'b0;
        check("solved_done", done, 1);
        check("solved_option", {15'd0, option_is_index, option}, 0);
        check("solved_push", dut.count_q, total_words() + 1);
        repeat (3) @(negedge clk);
        check("solved_held", done, 1);
        check("solved_no_pop", dut.count_q, total_words() + 1);

        // Random board, random keeps until a pass leaves every line unchanged
        do_reset();
        for (int l = 0; l < Lines; l++) begin
            int n = $urandom_range(0, 3);
            opts[l].delete();
            for (int k = 0; k < n; k++) opts[l].push_back($urandom_range(1, 16'hffff));
        end
        load_model();
        for (int p = 0; p < 10; p++) begin
            run_pass((p < 6) ? 1 : 0, Lines, sh);
            if (!sh) break;
        end
        check_stall("random_stall");

        // DEPTH=8 instance: fill, then one more word
        do_reset();
        for (int i = 0; i < 8; i++) begin
            int t = 0;
            s_valid = 1'b1; s_is_index = (i == 0); s_data = 16'(i);
            while (!s_ready && t < 5) begin @(negedge clk); t++; end
            check($sformatf("fill_ready%0d", i), s_ready, 1);
            @(negedge clk);
        end
        s_is_index = 1'b0; s_data = 16'd99;
        check("full_not_ready", s_ready, 0);
        check("full_no_ovf_yet", s_ovf, 0);
        @(negedge clk);
        s_valid = 1'b0;
        check("overflow_set", s_ovf, 1);
        check("full_count", dut8.count_q, 8);
        check("full_amnt0", s_amnt[0], 7);
        repeat (3) @(negedge clk);
        check("overflow_sticky", s_ovf, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
